// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - sched_state_e : scheduler FSM states
//   - CRC-16/CCITT defaults (MSB-first, no reflection, no final XOR)
//   - frame field widths
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StStart,
    StWait,
    StDone
  } sched_state_e;

  localparam logic [15:0] CrcPolyDefault = 16'h1021;
  localparam logic [15:0] CrcInitDefault = 16'hFFFF;

  localparam int unsigned DataBits = 8;
  localparam int unsigned CrcBits  = 16;

endpackage

// File: rtl/uart_tx_scheduler_crc16.sv
// Bit-serial CRC-16 engine, one message bit per enabled cycle, MSB first.
// Also used by the receive-side checker.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (register returns to INIT)
//   init     load INIT (has priority over shift_en)
//   shift_en absorb bit_in this cycle
//   bit_in   message bit
//   crc      current CRC register
module uart_tx_scheduler_crc16 import uart_tx_scheduler_pkg::*; #(
  parameter logic [15:0] POLY = CrcPolyDefault,
  parameter logic [15:0] INIT = CrcInitDefault
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [15:0]  crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ bit_in;
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (shift_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Latches the winning byte, computes its CRC-16 serially, launches the transmitter
// with a tx_start/tx_busy handshake and pulses ack for the owner when the frame ends.
// Optional feature: define UART_SCHED_TIMEOUT_EN for a START/WAIT watchdog
// (err_timeout pulse, frame abandoned without ack).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   req           level request per source, held until ack
//   req_data      byte per source, source i at [8*i+7:8*i]
//   ack           one-cycle pulse when source i's frame has been transmitted
//   grant         one-hot owner of the current frame, 0 when idle
//   tx_data       byte to transmitter
//   tx_crc        CRC of tx_data to transmitter
//   tx_start      launch request, held until tx_busy is seen
//   tx_busy       transmitter busy
//   sched_busy    high whenever not idle
//   err_timeout   watchdog expiry pulse (0 without UART_SCHED_TIMEOUT_EN)
module uart_tx_scheduler import uart_tx_scheduler_pkg::*; #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [15:0] CRC_POLY       = CrcPolyDefault,
  parameter logic [15:0] CRC_INIT       = CrcInitDefault,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic [DataBits-1:0]    tx_data,
  output logic [CrcBits-1:0]     tx_crc,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   sched_busy,
  output logic                   err_timeout
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_e          state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DataBits-1:0]   tx_data_q, tx_data_d;
  logic [CrcBits-1:0]    tx_crc_q, tx_crc_d;
  logic [3:0]            bitcnt_q, bitcnt_d;

  logic [PtrW-1:0]       winner;
  logic                  crc_init, crc_shift, crc_bit;
  logic [CrcBits-1:0]    crc_val;

  // First asserted request strictly after the last owner, wrapping.
  always_comb begin
    winner = ptr_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % NUM_REQ]) begin
        winner = PtrW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign crc_bit = tx_data_q[3'd7 - bitcnt_q[2:0]];

  uart_tx_scheduler_crc16 #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk      (clk),
    .reset_n  (reset_n),
    .init     (crc_init),
    .shift_en (crc_shift),
    .bit_in   (crc_bit),
    .crc      (crc_val)
  );

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [17:0] TimeoutLast = 18'(TIMEOUT_CYCLES - 1);
  logic [17:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  assign tmo_hit = ((state_q == StStart) || (state_q == StWait)) && (tmo_cnt_q == TimeoutLast);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_crc_d  = tx_crc_q;
    bitcnt_d  = bitcnt_q;
    crc_init  = 1'b0;
    crc_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d   = StCrc;
          ptr_d     = winner;
          grant_d   = OneHot0 << winner;
          tx_data_d = req_data[8*int'(winner) +: 8];
          bitcnt_d  = '0;
          crc_init  = 1'b1;
        end
      end
      StCrc: begin
        // Eight shift cycles, then one cycle to publish the finished CRC.
        if (bitcnt_q == 4'(DataBits)) begin
          tx_crc_d = crc_val;
          state_d  = StStart;
        end else begin
          crc_shift = 1'b1;
          bitcnt_d  = bitcnt_q + 4'd1;
        end
      end
      StStart: begin
        if (tx_busy) state_d = StWait;
      end
      StWait: begin
        // ack and grant swap on the same edge so they never overlap.
        if (!tx_busy) begin
          state_d = StDone;
          ack_d   = grant_q;
          grant_d = '0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef UART_SCHED_TIMEOUT_EN
    // ptr_q keeps the stalled owner so the next search starts after it.
    err_d = 1'b0;
    if (tmo_hit) begin
      state_d = StIdle;
      grant_d = '0;
      ack_d   = '0;
      err_d   = 1'b1;
    end
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StCrc && state_d == StStart) begin
      tmo_cnt_d = '0;
    end else if (state_q == StStart || state_q == StWait) begin
      tmo_cnt_d = tmo_cnt_q + 18'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= PtrW'(NUM_REQ - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_crc_q  <= '0;
      bitcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_crc_q  <= tx_crc_d;
      bitcnt_q  <= bitcnt_d;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_timeout    = 1'b0;
`endif

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign tx_data    = tx_data_q;
  assign tx_crc     = tx_crc_q;
  assign tx_start   = (state_q == StStart);
  assign sched_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (default build, four sources).
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack;
  logic [N-1:0]     grant;
  logic [7:0]       tx_data;
  logic [15:0]      tx_crc;
  logic             tx_start;
  logic             tx_busy;
  logic             sched_busy;
  logic             err_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m;

  uart_tx_scheduler #(
    .NUM_REQ (N)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_crc      (tx_crc),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/CCITT of one byte straight from the generator definition.
  function automatic logic [15:0] crc_model(input logic [7:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Round-robin reference: first requester after the previous owner.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Plays the transmitter for one frame and checks the scheduler side.
  task automatic serve_frame(input int owner, input logic [7:0] data, input int lo_cyc,
                             input int hi_cyc, input bit drop, output int lat);
    logic [N-1:0] oh;
    oh  = N'(1) << owner;
    lat = 0;
    while (!tx_start && lat < 100) begin
      tick;
      lat++;
    end
    chk("start_seen", 32'(tx_start), 1);
    chk("grant", 32'(grant), 32'(oh));
    chk("tx_data", 32'(tx_data), 32'(data));
    chk("tx_crc", 32'(tx_crc), 32'(crc_model(data)));
    chk("busy_in_frame", 32'(sched_busy), 1);
    req_data = {$urandom, $urandom};  // must not disturb the latched byte
    for (int i = 0; i < lo_cyc; i++) begin
      tick;
      chk("start_hold", {31'b0, tx_start}, 1);
      chk("no_early_ack", 32'(ack), 0);
    end
    tx_busy = 1'b1;
    tick;
    chk("start_drop", 32'(tx_start), 0);
    for (int i = 0; i < hi_cyc; i++) begin
      tick;
      chk("wait_hold", {4'b0, grant, tx_data, tx_crc}, {4'b0, oh, data, crc_model(data)});
      chk("no_relaunch", 32'(tx_start), 0);
    end
    tx_busy = 1'b0;
    tick;
    chk("ack", 32'(ack), 32'(oh));
    chk("grant_clear", 32'(grant), 0);
    if (drop) req[owner] = 1'b0;
    tick;
    chk("ack_pulse", 32'(ack), 0);
    ptr_m = owner;
  endtask

  initial begin
    int lat;
    int own;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] d;

    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    ptr_m    = N - 1;
    tick;
    tick;
    chk("reset_outs", {ack, grant, tx_data, tx_crc, tx_start, sched_busy, err_timeout},
        32'h0);
    reset_n = 1'b1;
    tick;
    chk("idle_busy", 32'(sched_busy), 0);

    // Single source 0, byte 00: latency and known CRC.
    req = 4'b0001;
    req_data = 32'h0;
    serve_frame(0, 8'h00, 5, 3, 1'b1, lat);
    chk("latency", 32'(lat), 10);
    chk("crc_00", 32'(crc_model(8'h00)), 32'hE1F0);

    // Single source 2, 'A'.
    req = 4'b0100;
    req_data = 32'h0041_0000;
    serve_frame(2, 8'h41, 0, 4, 1'b1, lat);
    chk("crc_A", 32'(crc_model(8'h41)), 32'hB915);

    // Reset while waiting for the transmitter.
    req = 4'b0010;
    req_data[15:8] = 8'h5A;
    lat = 0;
    while (!tx_start && lat < 100) begin
      tick;
      lat++;
    end
    chk("rst_frame_start", 32'(tx_start), 1);
    tx_busy = 1'b1;
    tick;
    chk("rst_in_wait", {30'b0, sched_busy, tx_start}, 32'b10);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", {ack, grant, tx_data, tx_crc, tx_start, sched_busy, err_timeout},
        32'h0);
    req     = '0;
    tx_busy = 1'b0;
    tick;
    reset_n = 1'b1;
    ptr_m   = N - 1;
    tick;

    // All four held: strict rotation starting at source 0.
    req = 4'b1111;
    req_data = {$urandom};
    for (int i = 0; i < 5; i++) begin
      own = pick(req, ptr_m);
      chk("rr_model", 32'(own), 32'(order[i]));
      d = req_data[8*order[i] +: 8];
      serve_frame(order[i], d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'b0, lat);
      if (i == 4) req = '0;
    end
    tick;
    tick;
    chk("idle_after_rr", {30'b0, sched_busy, tx_start}, 0);

    // Random traffic against the round-robin model.
    for (int k = 0; k < 16; k++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      req = req | N'($urandom_range(0, (1 << N) - 1));
      req_data = {$urandom};
      own = pick(req, ptr_m);
      d = req_data[8*own +: 8];
      serve_frame(own, d, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), lat);
      chk("rand_latency", 32'(lat), 10);
    end

    chk("no_timeout", 32'(err_timeout), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
